// File: rtl/fp_round_pack_pipe.sv
// fp_round_pack_pipe
// Two-stage round-and-pack back end for a floating-point multiplier.
// Stage A normalises the raw significand product. It extracts the stored
// fraction together with the guard and sticky bits. Stage B rounds the
// result (RNE or RTZ), resolves special operands and range exceptions, and
// registers the packed result and its flags. Both stages use a valid/ready
// handshake, so the block accepts one beat per cycle.
//
// Ports
//   clk, rst                    clock; asynchronous active-high reset
//   in_valid / in_ready         input handshake
//   in_sign, in_exp, in_man     product sign, signed biased exponent sum, raw significand product
//   in_nan, in_inf, in_zero     operand class tags
//   rnd_mode                    0 = round-nearest-even, 1 = round-toward-zero
//   out_valid / out_ready       output handshake
//   out_result                  packed {sign, exp, frac}
//   out_flags                   {nv, of, uf, nx} for the presented result
//   sticky_flags, flags_clr     accumulated flags and their synchronous clear
module fp_round_pack_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  localparam int PROD_W = 2 * (MAN_W + 1),
  localparam int OUT_W = 1 + EXP_W + MAN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_W+1:0]     in_exp,
  input  logic [PROD_W-1:0]    in_man,
  input  logic                 in_nan,
  input  logic                 in_inf,
  input  logic                 in_zero,
  input  logic                 rnd_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_result,
  output logic [3:0]           out_flags,
  output logic [3:0]           sticky_flags,
  input  logic                 flags_clr
);

  localparam logic [EXP_W+1:0] EXP_ONE  = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic [EXP_W+1:0] EXP_ZERO = {(EXP_W+2){1'b0}};
  localparam logic [EXP_W+1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};

  // Stage A registers
  logic               a_valid_r;
  logic [MAN_W-1:0]   a_frac_r;
  logic               a_guard_r;
  logic               a_sticky_r;
  logic [EXP_W+1:0]   a_exp_r;
  logic               a_sign_r;
  logic               a_nan_r;
  logic               a_inf_r;
  logic               a_zero_r;
  logic               a_rtz_r;
  logic               live_r;

  logic               b_load_s;
  logic [PROD_W-1:0]  man_n_s;
  logic [EXP_W+1:0]   exp_n_s;
  logic [MAN_W:0]     frac_sum_s;
  logic [EXP_W+1:0]   exp_rd_s;
  logic               inc_s;
  logic [OUT_W-1:0]   res_s;
  logic [3:0]         flg_s;

  // Stage B advances whenever its slot is empty or being drained.
  // live_r holds in_ready low until the first clock edge after reset.
  assign b_load_s = !out_valid || out_ready;
  assign in_ready = live_r && (!a_valid_r || b_load_s);

  // Normalise: a product in [2,4) is shifted right by one binade via the exponent
  always_comb begin
    if (in_man[PROD_W-1]) begin
      man_n_s = in_man;
      exp_n_s = in_exp + EXP_ONE;
    end else begin
      man_n_s = {in_man[PROD_W-2:0], 1'b0};
      exp_n_s = in_exp;
    end
  end

  // Round and resolve specials; the earlier branches take precedence over the later ones
  always_comb begin
    inc_s      = !a_rtz_r && a_guard_r && (a_sticky_r || a_frac_r[0]);
    frac_sum_s = {1'b0, a_frac_r} + {{MAN_W{1'b0}}, inc_s};
    // A carry out of the fraction leaves the low bits zero, so only the exponent moves.
    exp_rd_s   = a_exp_r + {{(EXP_W+1){1'b0}}, frac_sum_s[MAN_W]};
    res_s      = {OUT_W{1'b0}};
    flg_s      = 4'b0000;
    if (a_nan_r || (a_inf_r && a_zero_r)) begin
      res_s = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flg_s = {a_inf_r && a_zero_r, 3'b000};
    end else if (a_inf_r) begin
      res_s = {a_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero_r) begin
      res_s = {a_sign_r, {(EXP_W+MAN_W){1'b0}}};
    end else if ($signed(exp_rd_s) >= $signed(EXP_MAX)) begin
      flg_s = 4'b0101;
      if (a_rtz_r) begin
        res_s = {a_sign_r, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      end else begin
        res_s = {a_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
    end else if ($signed(exp_rd_s) <= $signed(EXP_ZERO)) begin
      res_s = {a_sign_r, {(EXP_W+MAN_W){1'b0}}};
      flg_s = 4'b0011;
    end else begin
      res_s = {a_sign_r, exp_rd_s[EXP_W-1:0], frac_sum_s[MAN_W-1:0]};
      flg_s = {3'b000, a_guard_r || a_sticky_r};
    end
  end

  // Stage A: capture normalised fields on input transfer, empty when drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_r     <= 1'b0;
      a_valid_r  <= 1'b0;
      a_frac_r   <= {MAN_W{1'b0}};
      a_guard_r  <= 1'b0;
      a_sticky_r <= 1'b0;
      a_exp_r    <= {(EXP_W+2){1'b0}};
      a_sign_r   <= 1'b0;
      a_nan_r    <= 1'b0;
      a_inf_r    <= 1'b0;
      a_zero_r   <= 1'b0;
      a_rtz_r    <= 1'b0;
    end else begin
      live_r <= 1'b1;
      if (in_ready) begin
        a_valid_r  <= in_valid;
        a_frac_r   <= man_n_s[PROD_W-2 -: MAN_W];
        a_guard_r  <= man_n_s[PROD_W-2-MAN_W];
        a_sticky_r <= |man_n_s[PROD_W-3-MAN_W:0];
        a_exp_r    <= exp_n_s;
        a_sign_r   <= in_sign;
        a_nan_r    <= in_nan;
        a_inf_r    <= in_inf;
        a_zero_r   <= in_zero;
        a_rtz_r    <= rnd_mode;
      end else begin
        a_valid_r <= a_valid_r;
      end
    end
  end

  // Stage B: register the packed result; hold it while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= {OUT_W{1'b0}};
      out_flags  <= 4'b0000;
    end else if (b_load_s) begin
      out_valid <= a_valid_r;
      if (a_valid_r) begin
        out_result <= res_s;
        out_flags  <= flg_s;
      end else begin
        out_result <= out_result;
        out_flags  <= out_flags;
      end
    end else begin
      out_valid <= out_valid;
    end
  end

  // Sticky flags: accumulate per transfer; a clear in the same cycle keeps only that transfer's flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= 4'b0000;
    end else if (out_valid && out_ready) begin
      if (flags_clr) begin
        sticky_flags <= out_flags;
      end else begin
        sticky_flags <= sticky_flags | out_flags;
      end
    end else if (flags_clr) begin
      sticky_flags <= 4'b0000;
    end else begin
      sticky_flags <= sticky_flags;
    end
  end

endmodule

// File: tb/tb_fp_round_pack_pipe.sv
// Testbench for fp_round_pack_pipe (bf16 defaults).
// The driver pushes the expected {result, flags} for each accepted beat into a queue.
// The monitor pops and compares on every output transfer.
// The monitor also tracks the expected sticky flags.
module tb_fp_round_pack_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = 10'd0;
  logic [15:0] in_man = 16'd0;
  logic        in_nan = 1'b0;
  logic        in_inf = 1'b0;
  logic        in_zero = 1'b0;
  logic        rnd_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic [3:0]  sticky_flags;
  logic        flags_clr = 1'b0;

  int n_checks = 0;
  int n_pass = 0;
  int acc_cnt = 0;
  logic [19:0] exp_q[$];
  logic [3:0]  sticky_m = 4'b0000;

  fp_round_pack_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man),
    .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .sticky_flags(sticky_flags), .flags_clr(flags_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endtask

  // Reference: value = man * 2^(exp - bias - 14). Round to 8 significant bits, then classify.
  function automatic logic [19:0] model(input logic s, input int e_in, input int man,
                                        input logic nan, input logic inf, input logic zero,
                                        input logic rtz);
    int drop, e, q, rem, half;
    logic nx;
    logic [7:0] ev;
    logic [6:0] fv;
    if (nan || (inf && zero)) return {16'h7FC0, (inf && zero) ? 4'b1000 : 4'b0000};
    if (inf) return {s, 8'hFF, 7'h00, 4'b0000};
    if (zero) return {s, 15'h0000, 4'b0000};
    drop = (man >= 32768) ? 8 : 7;
    e = e_in + ((man >= 32768) ? 1 : 0);
    q = man / (1 << drop);
    rem = man % (1 << drop);
    half = 1 << (drop - 1);
    nx = (rem != 0);
    if (!rtz && (rem > half || (rem == half && (q % 2) == 1))) q = q + 1;
    if (q == 256) begin
      q = 128;
      e = e + 1;
    end
    if (e >= 255) return rtz ? {s, 8'hFE, 7'h7F, 4'b0101} : {s, 8'hFF, 7'h00, 4'b0101};
    if (e <= 0) return {s, 15'h0000, 4'b0011};
    ev = e[7:0];
    fv = 7'(q - 128);
    return {s, ev, fv, 3'b000, nx};
  endfunction

  task automatic send(input logic s, input int e, input logic [15:0] m, input logic nan,
                      input logic inf, input logic zero, input logic rtz, input logic [19:0] want);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    in_sign = s; in_exp = 10'(e); in_man = m;
    in_nan = nan; in_inf = inf; in_zero = zero; rnd_mode = rtz; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      #3;
      if (in_ready) begin
        exp_q.push_back(want);
        acc_cnt++;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("send_accept_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_m(input logic s, input int e, input logic [15:0] m, input logic nan,
                        input logic inf, input logic zero, input logic rtz);
    send(s, e, m, nan, inf, zero, rtz, model(s, e, int'(m), nan, inf, zero, rtz));
  endtask

  // Monitor: scoreboard compare on output transfer and sticky-flag model
  initial begin
    logic [19:0] ev;
    logic [3:0] fl;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        sticky_m = 4'b0000;
      end else begin
        chk("sticky_flags", {28'd0, sticky_flags}, {28'd0, sticky_m});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {31'd0, out_valid}, 32'd0);
            fl = out_flags;
          end else begin
            ev = exp_q.pop_front();
            chk("out_result", {16'd0, out_result}, {16'd0, ev[19:4]});
            chk("out_flags", {28'd0, out_flags}, {28'd0, ev[3:0]});
            fl = ev[3:0];
          end
          sticky_m = flags_clr ? fl : (sticky_m | fl);
        end else if (flags_clr) begin
          sticky_m = 4'b0000;
        end
      end
    end
  end

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int a0;
    logic done;
    logic [3:0] r;
    int ma, mb;
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_result", {16'd0, out_result}, 32'd0);
    chk("reset_out_flags", {28'd0, out_flags}, 32'd0);
    chk("reset_sticky", {28'd0, sticky_flags}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // 1.5*1.5 and two-cycle latency
    send(1'b0, 127, 16'h9000, 1'b0, 1'b0, 1'b0, 1'b0, {16'h4010, 4'h0});
    chk("latency_cycle1", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("latency_cycle2", {31'd0, out_valid}, 32'd1);
    chk("latency_result", {16'd0, out_result}, 32'h4010);

    // Ties, rounding carry, overflow both modes, underflow, inf*0
    send(1'b0, 127, 16'h4040, 1'b0, 1'b0, 1'b0, 1'b0, {16'h3F80, 4'b0001});
    send(1'b0, 127, 16'h40C0, 1'b0, 1'b0, 1'b0, 1'b0, {16'h3F82, 4'b0001});
    send(1'b0, 126, 16'h7FC0, 1'b0, 1'b0, 1'b0, 1'b0, {16'h3F80, 4'b0001});
    send(1'b0, 255, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0, {16'h7F80, 4'b0101});
    send(1'b0, 255, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b1, {16'h7F7F, 4'b0101});
    send(1'b1, 0, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0, {16'h8000, 4'b0011});
    send(1'b0, 127, 16'h4000, 1'b0, 1'b1, 1'b1, 1'b0, {16'h7FC0, 4'b1000});
    send(1'b1, 127, 16'h4000, 1'b0, 1'b1, 1'b0, 1'b0, {16'hFF80, 4'b0000});
    send(1'b1, 127, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b0, {16'h8000, 4'b0000});
    drain();
    chk("sticky_accumulated", {28'd0, sticky_flags}, 32'hF);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    #3 chk("sticky_cleared", {28'd0, sticky_flags}, 32'd0);

    // Back-pressure: four beats with the consumer stalled
    @(negedge clk);
    out_ready = 1'b0;
    a0 = acc_cnt;
    fork
      begin
        send_m(1'b0, 120, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0);
        send_m(1'b1, 130, 16'hC3C3, 1'b0, 1'b0, 1'b0, 1'b1);
        send_m(1'b0, 100, 16'h6789, 1'b0, 1'b0, 1'b0, 1'b0);
        send_m(1'b1, 140, 16'hFEDC, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        #3;
        chk("stall_accepted", acc_cnt - a0, 32'd2);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight: outputs clear at once and nothing stale emerges
    out_ready = 1'b0;
    send_m(1'b0, 127, 16'h9000, 1'b0, 1'b0, 1'b0, 1'b0);
    send_m(1'b0, 127, 16'h40C0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_out_result", {16'd0, out_result}, 32'd0);
    chk("midreset_out_flags", {28'd0, out_flags}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("in_ready_after_midreset", {31'd0, in_ready}, 32'd1);
    repeat (5) @(negedge clk);
    #3 chk("no_stale_beat", {31'd0, out_valid}, 32'd0);

    // Randomised traffic with random back-pressure and clears
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          r = 4'($urandom_range(0, 15));
          ma = 128 + int'($urandom_range(0, 127));
          mb = 128 + int'($urandom_range(0, 127));
          send_m(1'($urandom_range(0, 1)), int'($urandom_range(0, 300)) - 20, 16'(ma * mb),
                 r == 4'd0, r == 4'd1 || r == 4'd3, r == 4'd2 || r == 4'd3,
                 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
          flags_clr = ($urandom_range(0, 15) == 0);
        end
        out_ready = 1'b1;
        flags_clr = 1'b0;
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
